// File: rtl/btn_pkg.sv
// Shared definitions for the button debounce controller.
// The package holds the register offsets, the counter width and the byte-lane mask helper.
package btn_pkg;

  localparam int CNT_W = 16;

  // Register offsets are word indices taken from addr[3:2].
  typedef enum logic [1:0] {
    REG_LEVEL = 2'd0,
    REG_PEND  = 2'd1,
    REG_IE    = 2'd2,
    REG_EDGE  = 2'd3
  } reg_sel_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// A single button channel: a two-flop synchronizer, a stability counter and the debounced level.
// It also produces one-cycle rise and fall pulses on the cycle after the level changes.
module btn_chan
  import btn_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = DEB_CYCLES - 16'd1;

  logic             sync_a;
  logic             sync_b;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // The counter restarts whenever the input agrees with the level, so glitches never accumulate.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_a  <= btn;
      sync_b  <= sync_a;
      level_q <= level;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/btn_debounce_ctrl.sv
// Debounced button controller with a small register file (LEVEL, PEND, IE, EDGE) and an interrupt.
// Each channel is handled by btn_chan; this module owns the bus decode, the registers and irq.
module btn_debounce_ctrl
  import btn_pkg::*;
#(
  parameter int               N_BTN      = 5,
  parameter logic [CNT_W-1:0] DEB_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  input  logic             enabler,
  input  logic             write_enabler,
  input  logic [31:0]      addr,
  input  logic [3:0]       select,
  input  logic [31:0]      data_input,
  output logic [31:0]      data_output,
  output logic [31:0]      wdata,
  output logic             irq
);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] ie;
  logic [N_BTN-1:0] edge_cfg;
  logic [N_BTN-1:0] event_hit;
  logic [N_BTN-1:0] wr_mask;
  logic [N_BTN-1:0] w1c;
  logic [31:0]      lane_bits;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             rd_en;
  reg_sel_e         sel_reg;
  logic             unused_bits;

  assign wr_en       = enabler & write_enabler;
  assign rd_en       = enabler & ~write_enabler;
  assign sel_reg     = reg_sel_e'(addr[3:2]);
  assign unused_bits = ^{addr[31:4], addr[1:0], data_input, lane_bits};

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // EDGE selects per channel which transition counts as an event.
  always_comb begin
    lane_bits = lane_mask(select);
    wr_mask   = lane_bits[N_BTN-1:0];
    event_hit = (edge_cfg & fall) | (~edge_cfg & rise);
    w1c       = '0;
    if (wr_en && sel_reg == REG_PEND) begin
      w1c = data_input[N_BTN-1:0] & wr_mask;
    end
    rd_mux = '0;
    case (sel_reg)
      REG_LEVEL: rd_mux[N_BTN-1:0] = level;
      REG_PEND:  rd_mux[N_BTN-1:0] = pend;
      REG_IE:    rd_mux[N_BTN-1:0] = ie;
      REG_EDGE:  rd_mux[N_BTN-1:0] = edge_cfg;
      default:   rd_mux = '0;
    endcase
    wdata = '0;
    wdata[N_BTN-1:0] = level;
  end

  // New events are OR-ed in after the clear so a simultaneous set beats a W1C.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend        <= '0;
      ie          <= '0;
      edge_cfg    <= '0;
      data_output <= '0;
      irq         <= 1'b0;
    end else begin
      irq  <= |(pend & ie);
      pend <= (pend & ~w1c) | event_hit;
      if (rd_en) begin
        data_output <= rd_mux;
      end
      if (wr_en && sel_reg == REG_IE) begin
        ie <= (ie & ~wr_mask) | (data_input[N_BTN-1:0] & wr_mask);
      end
      if (wr_en && sel_reg == REG_EDGE) begin
        edge_cfg <= (edge_cfg & ~wr_mask) | (data_input[N_BTN-1:0] & wr_mask);
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Self-checking bench for btn_debounce_ctrl: directed register scenarios plus a randomized
// button phase checked against a behavioural model of the debounce and event rules.
module tb_btn_debounce_ctrl;

  localparam int          NB  = 5;
  localparam int          DEB = 4;
  localparam logic [31:0] A_LEVEL = 32'h0;
  localparam logic [31:0] A_PEND  = 32'h4;
  localparam logic [31:0] A_IE    = 32'h8;
  localparam logic [31:0] A_EDGE  = 32'hC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn = '0;
  logic          enabler = 1'b0;
  logic          write_enabler = 1'b0;
  logic [31:0]   addr = '0;
  logic [3:0]    select = '0;
  logic [31:0]   data_input = '0;
  logic [31:0]   data_output;
  logic [31:0]   wdata;
  logic          irq;

  logic          btn1 = 1'b0;
  logic [31:0]   data_output1;
  logic [31:0]   wdata1;
  logic          irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_debounce_ctrl #(.N_BTN(NB), .DEB_CYCLES(16'(DEB))) dut (
    .clk(clk), .rst(rst), .btn(btn), .enabler(enabler), .write_enabler(write_enabler),
    .addr(addr), .select(select), .data_input(data_input),
    .data_output(data_output), .wdata(wdata), .irq(irq)
  );

  btn_debounce_ctrl #(.N_BTN(1), .DEB_CYCLES(16'd1)) dut1 (
    .clk(clk), .rst(rst), .btn(btn1), .enabler(1'b0), .write_enabler(1'b0),
    .addr(32'h0), .select(4'h0), .data_input(32'h0),
    .data_output(data_output1), .wdata(wdata1), .irq(irq1)
  );

  // Behavioural model: level flips after DEB consecutive synced samples disagreeing with it.
  logic [NB-1:0] m_s1, m_s2, m_level, m_ev, m_pend, m_ie, m_edge;
  logic          m_irq;
  int            m_run [NB];

  always @(posedge clk) begin
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_ev = '0; m_pend = '0; m_irq = 1'b0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
    end else begin
      m_irq  = |(m_pend & m_ie);
      m_pend = m_pend | m_ev;
      m_ev   = '0;
      for (int i = 0; i < NB; i++) begin
        if (m_s2[i] != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= DEB) begin
            m_level[i] = m_s2[i];
            m_run[i]   = 0;
            m_ev[i]    = m_edge[i] ? !m_s2[i] : m_s2[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    enabler = 1'b1; write_enabler = 1'b1; addr = a; data_input = d; select = s;
    @(negedge clk);
    enabler = 1'b0; write_enabler = 1'b0; select = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    enabler = 1'b1; write_enabler = 1'b0; addr = a;
    @(negedge clk);
    enabler = 1'b0;
    d = data_output;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b0;
    cyc(3);
    checks++; if (data_output !== 32'h0) begin errors++; $display("[TB] FAIL reset_dout: got %h expected %h", data_output, 32'h0); end
    checks++; if (wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected %h", wdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
    rst = 1'b1;
    cyc(1);
    for (int r = 0; r < 4; r++) begin
      bus_read(32'(r * 4), d);
      checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", r, d, 32'h0); end
    end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    btn[0] = 1'b1;
    cyc(3);
    btn[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      checks++; if (wdata !== 32'h0) begin errors++; $display("[TB] FAIL glitch_level: got %h expected %h", wdata, 32'h0); end
    end
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL glitch_pend: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_press;
    logic [31:0] d;
    btn[2] = 1'b1;
    cyc(5);
    checks++; if (wdata !== 32'h0) begin errors++; $display("[TB] FAIL press_early: got %h expected %h", wdata, 32'h0); end
    cyc(1);
    checks++; if (wdata !== 32'h4) begin errors++; $display("[TB] FAIL press_level: got %h expected %h", wdata, 32'h4); end
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL press_pend_same: got %h expected %h", d, 32'h0); end
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h4) begin errors++; $display("[TB] FAIL press_pend: got %h expected %h", d, 32'h4); end
    bus_read(A_LEVEL, d);
    checks++; if (d !== 32'h4) begin errors++; $display("[TB] FAIL press_level_reg: got %h expected %h", d, 32'h4); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL press_irq: got %b expected 0", irq); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    bus_write(A_IE, 32'h4, 4'hF);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_lag: got %b expected 0", irq); end
    cyc(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_set: got %b expected 1", irq); end
    bus_write(A_PEND, 32'h4, 4'hF);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_hold: got %b expected 1", irq); end
    cyc(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear: got %b expected 0", irq); end
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL irq_pend_w1c: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_edge_fall;
    logic [31:0] d;
    btn[2] = 1'b0;
    cyc(10);
    bus_write(A_EDGE, 32'h1, 4'hF);
    btn[0] = 1'b1;
    cyc(10);
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL edge_press: got %h expected %h", d, 32'h0); end
    btn[0] = 1'b0;
    cyc(10);
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL edge_release: got %h expected %h", d, 32'h1); end
    bus_write(A_PEND, 32'h1, 4'h1);
    bus_write(A_EDGE, 32'h0, 4'hF);
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    btn[1] = 1'b1;
    cyc(10);
    btn[1] = 1'b0;
    cyc(10);
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h2) begin errors++; $display("[TB] FAIL b2b_first: got %h expected %h", d, 32'h2); end
    btn[1] = 1'b1;
    cyc(6);
    bus_write(A_PEND, 32'h2, 4'hF);
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h2) begin errors++; $display("[TB] FAIL b2b_set_wins: got %h expected %h", d, 32'h2); end
    bus_write(A_PEND, 32'h2, 4'hF);
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL b2b_cleared: got %h expected %h", d, 32'h0); end
    btn[1] = 1'b0;
    cyc(10);
  endtask

  task automatic test_lane_mask;
    logic [31:0] d;
    bus_write(A_IE, 32'hFFFF_FFFF, 4'b0001);
    bus_read(A_IE, d);
    checks++; if (d !== 32'h1F) begin errors++; $display("[TB] FAIL lane_ie: got %h expected %h", d, 32'h1F); end
    bus_write(A_IE, 32'h0, 4'b1110);
    bus_read(32'hFFFF_FFF8, d);
    checks++; if (d !== 32'h1F) begin errors++; $display("[TB] FAIL lane_off: got %h expected %h", d, 32'h1F); end
    bus_write(A_EDGE, 32'hFFFF_FF00, 4'b1111);
    bus_read(A_EDGE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL lane_edge: got %h expected %h", d, 32'h0); end
    enabler = 1'b1; write_enabler = 1'b1; addr = A_LEVEL; data_input = 32'h1F; select = 4'hF;
    @(negedge clk);
    enabler = 1'b0; write_enabler = 1'b0;
    bus_read(A_LEVEL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL level_ro: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    bus_write(A_EDGE, 32'h3, 4'hF);
    bus_read(A_IE, d);
    btn = 5'h1F;
    cyc(4);
    rst = 1'b0;
    bus_write(A_IE, 32'h1F, 4'hF);
    rst = 1'b1;
    checks++; if (data_output !== 32'h0) begin errors++; $display("[TB] FAIL mid_dout: got %h expected %h", data_output, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL mid_irq: got %b expected 0", irq); end
    cyc(5);
    checks++; if (wdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_requal: got %h expected %h", wdata, 32'h0); end
    cyc(1);
    checks++; if (wdata !== 32'h1F) begin errors++; $display("[TB] FAIL mid_level: got %h expected %h", wdata, 32'h1F); end
    bus_read(A_IE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL mid_ie: got %h expected %h", d, 32'h0); end
    bus_read(A_EDGE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL mid_edge: got %h expected %h", d, 32'h0); end
    bus_read(A_PEND, d);
    checks++; if (d !== 32'h1F) begin errors++; $display("[TB] FAIL mid_pend: got %h expected %h", d, 32'h1F); end
    btn = '0;
    cyc(10);
  endtask

  task automatic test_deb1;
    btn1 = 1'b1;
    cyc(2);
    checks++; if (wdata1 !== 32'h0) begin errors++; $display("[TB] FAIL deb1_early: got %h expected %h", wdata1, 32'h0); end
    cyc(1);
    checks++; if (wdata1 !== 32'h1) begin errors++; $display("[TB] FAIL deb1_level: got %h expected %h", wdata1, 32'h1); end
    btn1 = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] d;
    logic [NB-1:0] ie_v, edge_v;
    int hold;
    rst = 1'b0;
    btn = '0;
    cyc(2);
    rst = 1'b1;
    ie_v   = NB'($urandom_range(1, 31));
    edge_v = NB'($urandom_range(0, 31));
    bus_write(A_IE, 32'(ie_v), 4'hF);
    m_ie = ie_v;
    bus_write(A_EDGE, 32'(edge_v), 4'hF);
    m_edge = edge_v;
    hold = 0;
    for (int k = 0; k < 600; k++) begin
      if (hold == 0) begin
        btn  = NB'($urandom_range(0, 31));
        hold = $urandom_range(1, 9);
      end
      hold--;
      cyc(1);
      checks++; if (wdata !== 32'(m_level)) begin errors++; $display("[TB] FAIL rnd_level: got %h expected %h", wdata, 32'(m_level)); end
      checks++; if (irq !== m_irq) begin errors++; $display("[TB] FAIL rnd_irq: got %b expected %b", irq, m_irq); end
    end
    cyc(12);
    bus_read(A_PEND, d);
    checks++; if (d !== 32'(m_pend)) begin errors++; $display("[TB] FAIL rnd_pend: got %h expected %h", d, 32'(m_pend)); end
  endtask

  initial begin
    m_ie = '0;
    m_edge = '0;
    @(negedge clk);
    test_reset;
    test_glitch;
    test_press;
    test_irq;
    test_edge_fall;
    test_back_to_back;
    test_lane_mask;
    test_reset_mid;
    test_deb1;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
